er_exec_sequencer: RTL
======================

Name: er_exec_sequencer

Overview:
- Controller that sequences one proof-of-execution run over an executable region (ER).
- Holds the ER bounds in software-writable config registers and locks them while a run is armed or active.
- Tracks PC entry and exit, aborts on ER modification (CPU or DMA), interrupt, or illegal exit, and raises exec on clean completion.
- Counts run cycles and hands completion to the attestation engine with a req/ack handshake.
- Sits beside the MSP430 core, fed by the same pc/data/dma taps as the ER monitor.

Parameters:
CNT_W, 16, width of run_cycles counter (saturating)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cfg_wr  input  1  config write strobe (single-cycle)
cfg_addr  input  1  0 = ER_min, 1 = ER_max
cfg_wdata  input  16  config write data
arm  input  1  single-cycle request to arm a run
pc  input  16  current program counter
data_addr  input  16  CPU data address
data_en  input  1  CPU write enable
dma_addr  input  16  DMA address
dma_en  input  1  DMA write enable
irq  input  1  interrupt taken by core
att_ack  input  1  attestation engine accepts result
er_min  output  16  registered ER lower bound
er_max  output  16  registered ER upper bound
exec  output  1  1 = last run completed cleanly and ER untouched since
busy  output  1  1 in ARMED or RUN
cfg_err  output  1  sticky: arm refused because er_min > er_max
run_cycles  output  CNT_W  cycles spent in RUN for last run
att_req  output  1  completion request to attestation engine

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - er_min, er_max, run_cycles, prev_pc = 0.
  - exec, busy, cfg_err, att_req = 0.
- All outputs are registered.
- Violation (viol), combinational:
  - (data_en && er_min<=data_addr<=er_max) || (dma_en && er_min<=dma_addr<=er_max).
  - Bounds are inclusive.
- prev_pc register: loads pc every cycle.
- States: IDLE, ARMED, RUN, DONE, ABORT.
- Config writes:
  - Accepted in IDLE, DONE, ABORT; ignored in ARMED and RUN.
  - A write in DONE or ABORT also moves the state to IDLE and clears exec and att_req.
- arm handling (IDLE, DONE, ABORT):
  - er_min<=er_max → ARMED next cycle. run_cycles, exec, att_req and cfg_err clear.
  - Otherwise → state unchanged, cfg_err=1.
  - arm in ARMED or RUN is ignored.
  - If cfg_wr and arm occur in the same cycle, the write takes effect and arm is ignored.
- ARMED:
  - viol → ABORT.
  - Else pc==er_min → RUN, run_cycles=1.
  - Else stay.
- RUN (priority order):
  1. viol or irq → ABORT.
  2. pc outside [er_min,er_max] with prev_pc==er_max → DONE.
  3. pc outside with prev_pc!=er_max → ABORT (illegal exit).
  4. Else stay; run_cycles+1, saturating at all-ones.
- DONE:
  - exec=1, att_req=1.
  - att_req drops the cycle after att_ack is sampled high and stays low; state remains DONE.
  - viol → ABORT, exec=0, att_req=0.
  - Re-entry at pc==er_min from DONE does not start a run; only arm does.
- ABORT: exec=0, att_req=0, run_cycles holds its last value.
- busy = (state==ARMED || state==RUN).
- Latency: state and exec update on the clock edge following the qualifying input cycle.
- Reset mid-run returns to IDLE immediately; no att_req is emitted.
- Violation always outranks entry/exit in the same cycle.

Decomposition:
- Package apex_seq_pkg:
  - state enum (IDLE, ARMED, RUN, DONE, ABORT).
  - CFG_ER_MIN=0, CFG_ER_MAX=1.
  - Default CNT_W.
- Sub-module er_range_check:
  - Combinational inclusive-range comparator (addr, en, lo, hi → hit).
  - Instantiated twice (CPU, DMA); the violation is their OR.

Test Plan:
- cfg ER_min=0xE000, ER_max=0xE010; arm; pc walks 0xE000..0xE010, then 0xE200 → RUN for 17 cycles, DONE, exec=1, run_cycles=17, att_req=1 until att_ack, then 0.
- Same setup, pc jumps 0xE008 → 0xC000 → ABORT, exec=0, busy=0.
- RUN with data_en=1, data_addr=0xE010 (upper bound) → ABORT; repeat with dma_addr=0xE000 in ARMED → ABORT; dma_addr=0xE011 → no effect.
- DONE then CPU write to 0xE004 → exec falls to 0 next cycle, state ABORT.
- cfg ER_min=0xF000, ER_max=0xE000, arm → cfg_err=1, state IDLE; cfg_wr in RUN → er_min unchanged.
- reset_n low while in RUN at pc=0xE005 → all outputs 0 asynchronously; CNT_W=4 run of 20 cycles → run_cycles=15.

Source files
------------

// File: rtl/er_exec_sequencer_pkg.sv
// Shared types and constants for the proof-of-execution sequencer.
package apex_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_DONE,
    ST_ABORT
  } seq_state_e;

  localparam logic CFG_ER_MIN = 1'b0;
  localparam logic CFG_ER_MAX = 1'b1;
  localparam int   DEF_CNT_W  = 16;
endpackage

// File: rtl/er_range_check.sv
// Inclusive address window hit: en && lo <= addr <= hi.
module er_range_check #(
  parameter int AW = 16
) (
  input  logic [AW-1:0] addr,
  input  logic          en,
  input  logic [AW-1:0] lo,
  input  logic [AW-1:0] hi,
  output logic          hit
);
  assign hit = en && (addr >= lo) && (addr <= hi);
endmodule

// File: rtl/er_exec_sequencer.sv
// Sequences one proof-of-execution run over the ER and reports clean completion
// to the attestation engine through a req/ack handshake.
module er_exec_sequencer
  import apex_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_wr,
  input  logic             cfg_addr,
  input  logic [15:0]      cfg_wdata,
  input  logic             arm,
  input  logic [15:0]      pc,
  input  logic [15:0]      data_addr,
  input  logic             data_en,
  input  logic [15:0]      dma_addr,
  input  logic             dma_en,
  input  logic             irq,
  input  logic             att_ack,
  output logic [15:0]      er_min,
  output logic [15:0]      er_max,
  output logic             exec,
  output logic             busy,
  output logic             cfg_err,
  output logic [CNT_W-1:0] run_cycles,
  output logic             att_req
);

  seq_state_e       state_q, state_d;
  logic [15:0]      er_min_q, er_min_d, er_max_q, er_max_d, prev_pc_q, prev_pc_d;
  logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
  logic             exec_q, exec_d, busy_q, busy_d, cfg_err_q, cfg_err_d;
  logic             att_req_q, att_req_d;

  logic cpu_hit, dma_hit, viol, pc_in_er, bounds_ok, cfg_open, wr_en, arm_en;

  er_range_check u_cpu_chk (
    .addr (data_addr),
    .en   (data_en),
    .lo   (er_min_q),
    .hi   (er_max_q),
    .hit  (cpu_hit)
  );

  er_range_check u_dma_chk (
    .addr (dma_addr),
    .en   (dma_en),
    .lo   (er_min_q),
    .hi   (er_max_q),
    .hit  (dma_hit)
  );

  assign viol      = cpu_hit | dma_hit;
  assign pc_in_er  = (pc >= er_min_q) && (pc <= er_max_q);
  assign bounds_ok = (er_min_q <= er_max_q);

  // A violation in DONE swallows the whole cycle, including any config write or arm.
  assign cfg_open = (state_q == ST_IDLE) || (state_q == ST_ABORT) ||
                    ((state_q == ST_DONE) && !viol);
  assign wr_en    = cfg_open && cfg_wr;
  assign arm_en   = cfg_open && arm && !cfg_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ABORT: begin
        if ((state_q == ST_DONE) && viol) state_d = ST_ABORT;
        else if (wr_en)                   state_d = ST_IDLE;
        else if (arm_en && bounds_ok)     state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (viol)                state_d = ST_ABORT;
        else if (pc == er_min_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (viol || irq) state_d = ST_ABORT;
        else if (!pc_in_er)
          state_d = (prev_pc_q == er_max_q) ? ST_DONE : ST_ABORT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    er_min_d     = er_min_q;
    er_max_d     = er_max_q;
    prev_pc_d    = pc;
    run_cycles_d = run_cycles_q;
    cfg_err_d    = cfg_err_q;
    att_req_d    = att_req_q;
    if (wr_en && (cfg_addr == CFG_ER_MIN)) er_min_d = cfg_wdata;
    if (wr_en && (cfg_addr == CFG_ER_MAX)) er_max_d = cfg_wdata;
    if (arm_en) cfg_err_d = !bounds_ok;
    if (arm_en && bounds_ok)
      run_cycles_d = '0;
    else if ((state_q == ST_ARMED) && (state_d == ST_RUN))
      run_cycles_d = CNT_W'(1);
    else if ((state_q == ST_RUN) && (state_d == ST_RUN) && (run_cycles_q != '1))
      run_cycles_d = run_cycles_q + CNT_W'(1);
    // Request rises on completion, falls for good once acked, dies on leaving DONE.
    if (state_d != ST_DONE)      att_req_d = 1'b0;
    else if (state_q == ST_RUN)  att_req_d = 1'b1;
    else if (att_ack)            att_req_d = 1'b0;
    exec_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_ARMED) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      er_min_q     <= '0;
      er_max_q     <= '0;
      prev_pc_q    <= '0;
      run_cycles_q <= '0;
      exec_q       <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      att_req_q    <= 1'b0;
    end else begin
      er_min_q     <= er_min_d;
      er_max_q     <= er_max_d;
      prev_pc_q    <= prev_pc_d;
      run_cycles_q <= run_cycles_d;
      exec_q       <= exec_d;
      busy_q       <= busy_d;
      cfg_err_q    <= cfg_err_d;
      att_req_q    <= att_req_d;
    end
  end

  assign er_min     = er_min_q;
  assign er_max     = er_max_q;
  assign exec       = exec_q;
  assign busy       = busy_q;
  assign cfg_err    = cfg_err_q;
  assign run_cycles = run_cycles_q;
  assign att_req    = att_req_q;

endmodule
